// File: rtl/fifo_rd_serializer_pkg.sv
// fifo_pkg: shared FIFO widths and serializer state encoding
package fifo_pkg;
   localparam int DEF_DATA_W = 128;
   localparam int DEF_OUT_W  = 32;
   typedef enum logic {S_IDLE, S_SEND} ser_state_e;
endpackage

// File: rtl/fifo_rd_serializer_if.sv
// fifo_rd_serializer_if: FIFO read port plus narrow valid/ready beat stream
interface fifo_rd_serializer_if
   import fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int OUT_W  = DEF_OUT_W
);
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_rddata;
   logic              fifo_rden;
   logic              en;
   logic              flush;
   logic              valid;
   logic [OUT_W-1:0]  data;
   logic              last;
   logic              ready;
   logic              busy;
   modport master (
      input  fifo_empty, fifo_rddata, en, flush, ready,
      output fifo_rden, valid, data, last, busy
   );
   modport slave (
      output fifo_empty, fifo_rddata, en, flush, ready,
      input  fifo_rden, valid, data, last, busy
   );
endinterface

// File: rtl/fifo_rd_serializer.sv
// fifo_rd_serializer: pops FIFO words and emits them as LSB-first narrow beats with burst last
module fifo_rd_serializer
   import fifo_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int OUT_W     = DEF_OUT_W,
   parameter int BURST_LEN = 4
) (
   input logic                  clk,
   input logic                  rstn,
   fifo_rd_serializer_if.master bus
);
   localparam int RATIO = DATA_W / OUT_W;
   localparam int BW    = $clog2(RATIO);
   localparam int WW    = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
   if (DATA_W % OUT_W != 0) begin : g_bad_ratio
      $error("DATA_W must be a multiple of OUT_W");
   end
   if (RATIO < 2) begin : g_bad_min
      $error("DATA_W/OUT_W must be at least 2");
   end
   if (BURST_LEN < 1) begin : g_bad_burst
      $error("BURST_LEN must be at least 1");
   end
   ser_state_e                   state, state_nx;
   logic [RATIO-1:0][OUT_W-1:0]  hold_rg;
   logic [BW-1:0]                beat_rg;
   logic [WW-1:0]                word_rg;
   logic                         last_beat, acc, fin, pop;
   always_comb begin
      last_beat = beat_rg == BW'(RATIO - 1);
      acc       = bus.valid & bus.ready;
      fin       = acc & last_beat;
      pop       = rstn & !bus.flush & bus.en & !bus.fifo_empty & (state == S_IDLE | fin);
      state_nx  = bus.flush ? S_IDLE : pop ? S_SEND : fin ? S_IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= S_IDLE;
         hold_rg <= '0;
         beat_rg <= '0;
         word_rg <= '0;
      end else if (bus.flush) begin
         state   <= S_IDLE;
         beat_rg <= '0;
         word_rg <= '0;
      end else begin
         state <= state_nx;
         if (pop) begin
            hold_rg <= bus.fifo_rddata;
            beat_rg <= '0;
         end else if (fin) beat_rg <= '0;
         else if (acc) beat_rg <= beat_rg + 1'b1;
         if (fin) word_rg <= word_rg == WW'(BURST_LEN - 1) ? '0 : word_rg + 1'b1;
      end
   end
   assign bus.fifo_rden = pop;
   assign bus.valid     = state == S_SEND;
   assign bus.busy      = state == S_SEND;
   assign bus.data      = bus.valid ? hold_rg[beat_rg] : '0;
   assign bus.last      = bus.valid & last_beat & (word_rg == WW'(BURST_LEN - 1));
endmodule

// File: tb/tb_fifo_rd_serializer.sv
// tb_fifo_rd_serializer: directed T1-T6 plus random traffic against a beat-list scoreboard
module tb_fifo_rd_serializer;
   import fifo_pkg::*;
   localparam int DW = 128, OW = 32, BL = 4, RATIO = DW / OW;
   typedef struct packed {logic [OW-1:0] d; logic l;} beat_t;
   logic clk = 0, rstn = 0;
   always #5 clk = ~clk;
   fifo_rd_serializer_if #(.DATA_W(DW), .OUT_W(OW)) bus ();
   fifo_rd_serializer #(.DATA_W(DW), .OUT_W(OW), .BURST_LEN(BL)) dut (.clk(clk), .rstn(rstn), .bus(bus));
   logic [DW-1:0] fifo_q[$];
   beat_t         exp_q[$];
   int            last_pos[$];
   int checks = 0, errors = 0;
   int wcnt = 0, n_valid = 0, n_rden = 0, n_acc = 0, n_rise = 0;
   logic prev_valid = 0, chk_zero = 0;
   task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic upd_fifo();
      bus.fifo_empty  = fifo_q.size() == 0;
      bus.fifo_rddata = fifo_q.size() != 0 ? fifo_q[0] : '0;
   endtask
   task automatic push(logic [DW-1:0] w);
      fifo_q.push_back(w);
      upd_fifo();
   endtask
   task automatic clr_stats();
      n_valid = 0; n_rden = 0; n_acc = 0; n_rise = 0;
      last_pos.delete();
   endtask
   task automatic cycle();
      logic ev, acc, fin, er, popd;
      logic [DW-1:0] w;
      upd_fifo();
      #1;
      ev = exp_q.size() > 0;
      check("valid", bus.valid, ev);
      check("busy", bus.busy, ev);
      if (ev) begin
         check("data", bus.data, exp_q[0].d);
         check("last", bus.last, exp_q[0].l);
      end else check("last_idle", bus.last, 0);
      if (chk_zero) check("data_after_reset", bus.data, 0);
      acc = ev & bus.ready;
      fin = acc & (exp_q.size() == 1);
      er  = rstn & !bus.flush & bus.en & (fifo_q.size() > 0) & (!ev | fin);
      check("rden", bus.fifo_rden, er);
      n_valid += int'(bus.valid);
      n_rden  += int'(bus.fifo_rden);
      if (bus.valid & !prev_valid) n_rise++;
      prev_valid = bus.valid;
      if (acc && rstn && !bus.flush) begin
         if (bus.last) last_pos.push_back(n_acc);
         n_acc++;
      end
      if (!rstn || bus.flush) begin
         exp_q.delete();
         wcnt = 0;
      end else begin
         if (acc) void'(exp_q.pop_front());
         if (fin) wcnt = (wcnt + 1) % BL;
         if (er) begin
            w = fifo_q[0];
            for (int k = 0; k < RATIO; k++) exp_q.push_back({w[k*OW +: OW], (k == RATIO - 1) && (wcnt == BL - 1)});
         end
      end
      chk_zero = !rstn;
      popd = bus.fifo_rden;
      @(posedge clk);
      #1;
      if (popd && fifo_q.size() > 0) void'(fifo_q.pop_front());
      @(negedge clk);
   endtask
   task automatic run(int n);
      repeat (n) cycle();
   endtask
   function automatic logic [DW-1:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   initial begin
      logic [DW-1:0] w;
      bus.en = 1; bus.flush = 0; bus.ready = 1;
      upd_fifo();
      run(2);
      rstn = 1;
      run(1);
      // T1 single word
      clr_stats();
      push(128'h0000000D_0000000C_0000000B_0000000A);
      run(8);
      check("t1_rden_cycles", n_rden, 1);
      check("t1_beats", n_valid, 4);
      check("t1_contiguous", n_rise, 1);
      // T2 two back-to-back bursts from a clean word count
      bus.flush = 1; run(1); bus.flush = 0;
      clr_stats();
      for (int i = 0; i < 8; i++) push(rnd_word());
      run(40);
      check("t2_beats", n_valid, 32);
      check("t2_contiguous", n_rise, 1);
      check("t2_nlast", last_pos.size(), 2);
      check("t2_last0", last_pos.size() > 0 ? last_pos[0] : -1, 15);
      check("t2_last1", last_pos.size() > 1 ? last_pos[1] : -1, 31);
      // T3 backpressure at beat 1 with a second word waiting
      w = rnd_word();
      push(w); push(rnd_word());
      run(2);
      bus.ready = 0;
      clr_stats();
      repeat (3) begin
         run(1);
         check("t3_hold", bus.data, w[63:32]);
      end
      check("t3_no_pop", n_rden, 0);
      bus.ready = 1;
      check("t3_resume", bus.data, w[63:32]);
      run(1);
      check("t3_beat2", bus.data, w[95:64]);
      run(10);
      // T4 underrun gap between words
      bus.flush = 1; run(1); bus.flush = 0;
      clr_stats();
      push(rnd_word());
      run(5);
      n_valid = 0;
      run(5);
      check("t4_gap_idle", n_valid, 0);
      for (int i = 0; i < 3; i++) push(rnd_word());
      run(16);
      check("t4_beats", n_acc, 16);
      check("t4_nlast", last_pos.size(), 1);
      check("t4_last", last_pos.size() > 0 ? last_pos[0] : -1, 15);
      // T5 flush at beat 2
      push(rnd_word());
      run(3);
      bus.flush = 1; run(1); bus.flush = 0;
      #1 check("t5_valid_dropped", bus.valid, 0);
      clr_stats();
      for (int i = 0; i < 4; i++) push(rnd_word());
      run(25);
      check("t5_beats", n_acc, 16);
      check("t5_last", last_pos.size() == 1 ? last_pos[0] : -1, 15);
      // T6 reset at beat 1
      push(rnd_word()); push(rnd_word());
      run(2);
      rstn = 0; run(1); rstn = 1;
      #1 check("t6_valid", bus.valid, 0);
      check("t6_last", bus.last, 0);
      clr_stats();
      run(10);
      check("t6_restart_beats", n_acc, 4);
      // random traffic
      for (int c = 0; c < 3000; c++) begin
         bus.ready = $urandom_range(0, 3) != 0;
         bus.en    = $urandom_range(0, 7) != 0;
         bus.flush = $urandom_range(0, 99) == 0;
         rstn      = $urandom_range(0, 499) != 0;
         if (fifo_q.size() < 8 && $urandom_range(0, 2) == 0) push(rnd_word());
         cycle();
      end
      rstn = 1; bus.ready = 1; bus.en = 1; bus.flush = 0;
      run(60);
      check("drain_fifo", fifo_q.size(), 0);
      check("drain_idle", bus.busy, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
